// File: rtl/fb_sram_arbiter.sv
// fb_sram_arbiter: shares the single framebuffer SRAM between the display
// scan-out read port and the draw engine write port, and owns the
// front/back buffer select that flips only at vertical blank.
// Optional feature macro: FB_ARB_STARVE_GUARD_EN (when defined, the draw
// engine is granted after STARVE_LIMIT consecutive display grants).
module fb_sram_arbiter #(
    parameter logic [19:0] DBUF_OFFSET  = 20'h4b000,
    parameter int          READ_LAT     = 2,
    parameter int          WRITE_LAT    = 2,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic        BOARD_CLK,
    input  logic        RESET,
    input  logic        queueRead,
    input  logic [19:0] framebufferAddress,
    output logic        dataReady,
    output logic [15:0] framebufferData,
    input  logic        draw_req,
    input  logic [19:0] draw_addr,
    input  logic [15:0] draw_data,
    output logic        draw_ack,
    input  logic        swap_req,
    input  logic        vblank_start,
    output logic        doubleBuffer,
    output logic        swap_done,
    output logic [19:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_OUT,
    output logic        SRAM_DQ_OE,
    input  logic [15:0] SRAM_DQ_IN,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N
);

    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [19:0]        addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               ready_q, ready_d;
    logic               ack_q, ack_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               dq_oe_q, dq_oe_d;
    logic               db_q, db_d;
    logic               swap_pending_q, swap_pending_d;
    logic               swap_done_q, swap_done_d;
    logic               grant_draw_s;
    logic               swap_fire_s;

`ifdef FB_ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

    // Draw wins when display is idle or has used up its consecutive grants.
    always_comb begin
        grant_draw_s = draw_req &&
                       (!queueRead || (starve_cnt_q == STARVE_W'(STARVE_LIMIT)));
    end

    // Count display grants that overtake a waiting draw request.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!draw_req) begin
            starve_cnt_d = '0;
        end else if ((state_q == ST_IDLE) && grant_draw_s) begin
            starve_cnt_d = '0;
        end else if ((state_q == ST_IDLE) && queueRead) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge BOARD_CLK) begin
        if (RESET) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    // Strict display priority: draw only when display is not asking.
    always_comb begin
        grant_draw_s = draw_req && !queueRead;
    end
`endif

    // Grant decision, access sequencing and next values of the SRAM pins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        ack_d   = 1'b0;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_draw_s) begin
                    // Back buffer is the one not being displayed right now.
                    state_d = ST_WRITE;
                    cnt_d   = CNT_W'(1);
                    addr_d  = draw_addr + (db_q ? 20'h00000 : DBUF_OFFSET);
                    wdata_d = draw_data;
                    ce_n_d  = 1'b0;
                    we_n_d  = 1'b0;
                    dq_oe_d = 1'b1;
                end else if (queueRead) begin
                    state_d = ST_READ;
                    cnt_d   = CNT_W'(1);
                    addr_d  = framebufferAddress;
                    ce_n_d  = 1'b0;
                    oe_n_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (cnt_q == CNT_W'(READ_LAT)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rdata_d = SRAM_DQ_IN;
                    ready_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    ce_n_d  = 1'b0;
                    oe_n_d  = 1'b0;
                end
            end
            ST_WRITE: begin
                if (cnt_q == CNT_W'(WRITE_LAT)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    ce_n_d  = 1'b0;
                    we_n_d  = 1'b0;
                    dq_oe_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Buffer flip: a pending (or same-cycle) swap request fires at vblank.
    always_comb begin
        swap_fire_s = vblank_start && (swap_pending_q || swap_req);
        swap_done_d = swap_fire_s;
        if (swap_fire_s) begin
            db_d           = ~db_q;
            swap_pending_d = 1'b0;
        end else if (swap_req) begin
            db_d           = db_q;
            swap_pending_d = 1'b1;
        end else begin
            db_d           = db_q;
            swap_pending_d = swap_pending_q;
        end
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge BOARD_CLK) begin
        if (RESET) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            addr_q         <= 20'h00000;
            wdata_q        <= 16'h0000;
            rdata_q        <= 16'h0000;
            ready_q        <= 1'b0;
            ack_q          <= 1'b0;
            ce_n_q         <= 1'b1;
            oe_n_q         <= 1'b1;
            we_n_q         <= 1'b1;
            dq_oe_q        <= 1'b0;
            db_q           <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rdata_q        <= rdata_d;
            ready_q        <= ready_d;
            ack_q          <= ack_d;
            ce_n_q         <= ce_n_d;
            oe_n_q         <= oe_n_d;
            we_n_q         <= we_n_d;
            dq_oe_q        <= dq_oe_d;
            db_q           <= db_d;
            swap_pending_q <= swap_pending_d;
            swap_done_q    <= swap_done_d;
        end
    end

    assign dataReady       = ready_q;
    assign framebufferData = rdata_q;
    assign draw_ack        = ack_q;
    assign doubleBuffer    = db_q;
    assign swap_done       = swap_done_q;
    assign SRAM_ADDR       = addr_q;
    assign SRAM_DQ_OUT     = wdata_q;
    assign SRAM_DQ_OE      = dq_oe_q;
    assign SRAM_CE_N       = ce_n_q;
    assign SRAM_OE_N       = oe_n_q;
    assign SRAM_WE_N       = we_n_q;

endmodule
